// File: rtl/key_pkg.sv
// Shared types and constants for the key_event decoder: FSM state encoding,
// counter width, default cycle counts and the saturating counter step.
package key_pkg;

    localparam int CNT_W = 24;

    localparam logic [CNT_W-1:0] LONG_CYC_DEF   = 24'd15_000_000;
    localparam logic [CNT_W-1:0] DBL_CYC_DEF    = 24'd10_000_000;
    localparam logic [CNT_W-1:0] REPEAT_CYC_DEF = 24'd5_000_000;
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    // Holds at all-ones instead of wrapping, so a very long hold never re-fires.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/key_event_if.sv
// Key level in, event pulses out. The debouncer side is master, the decoder slave.
// "release" is a language keyword, so the release pulse is carried as "released".
interface key_event_if;

    logic key;
    logic press;
    logic released;
    logic long_press;
    logic dbl_click;
    logic rpt;
    logic held;

    modport master (
        output key,
        input  press, released, long_press, dbl_click, rpt, held
    );

    modport slave (
        input  key,
        output press, released, long_press, dbl_click, rpt, held
    );

endinterface

// File: rtl/key_edge.sv
// Registers the debounced key level and derives single-cycle rise/fall strobes.
module key_edge (
    input  logic clk,
    input  logic rstn,
    input  logic key,
    output logic key_q,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    // Clearing key_q in reset makes a key held through reset look like a fresh press.
    assign rise = key & ~key_q;
    assign fall = ~key & key_q;

endmodule

// File: rtl/key_event.sv
// Button event decoder: press / release / long press / double click pulses from a
// debounced key level. Define KEY_REPEAT_EN to compile in auto-repeat while held.
module key_event
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] LONG_CYC   = LONG_CYC_DEF,
    parameter logic [CNT_W-1:0] DBL_CYC    = DBL_CYC_DEF,
    parameter logic [CNT_W-1:0] REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic      clk,
    input  logic      rstn,
    key_event_if.slave kbus
);

    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYC - ONE;
    localparam logic [CNT_W-1:0] DBL_LAST  = DBL_CYC - ONE;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;

    logic key_q;
    logic rise;
    logic fall;

    logic press_d;
    logic rel_d;
    logic long_d;
    logic dbl_d;
    logic press_p1;
    logic rel_p1;
    logic long_p1;
    logic dbl_p1;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = REPEAT_CYC - ONE;
    logic rpt_d;
    logic rpt_p1;
`endif

    key_edge u_edge (
        .clk   (clk),
        .rstn  (rstn),
        .key   (kbus.key),
        .key_q (key_q),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d = state;
        cnt_clr = 1'b0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    rel_d   = 1'b1;
                    state_d = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            WAIT2: begin
                // A rise on the timeout cycle still counts as the second click.
                if (rise) begin
                    press_d = 1'b1;
                    dbl_d   = 1'b1;
                    state_d = HELD2;
                end else if (cnt == DBL_LAST) begin
                    state_d = IDLE;
                end
            end
            HELD2: begin
                if (fall) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            LONG: begin
                if (fall) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt == RPT_LAST) begin
                    rpt_d   = 1'b1;
                    cnt_clr = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state) begin
            cnt_clr = 1'b1;
        end
    end

    // ---- stage p1: state, counter and registered event pulses ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            press_p1 <= 1'b0;
            rel_p1   <= 1'b0;
            long_p1  <= 1'b0;
            dbl_p1   <= 1'b0;
        end else begin
            state    <= state_d;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= sat_inc(cnt);
            end
            press_p1 <= press_d;
            rel_p1   <= rel_d;
            long_p1  <= long_d;
            dbl_p1   <= dbl_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rpt_p1 <= 1'b0;
        end else begin
            rpt_p1 <= rpt_d;
        end
    end

    assign kbus.rpt = rpt_p1;
`else
    assign kbus.rpt = 1'b0;
`endif

    assign kbus.press      = press_p1;
    assign kbus.released   = rel_p1;
    assign kbus.long_press = long_p1;
    assign kbus.dbl_click  = dbl_p1;
    assign kbus.held       = key_q;

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: stimulus tasks queue the expected pulse and its
// clock edge; a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_key_event;

    localparam logic [23:0] LONG = 24'd8;
    localparam logic [23:0] DBL  = 24'd5;
    localparam logic [23:0] RPT  = 24'd3;

    localparam logic [4:0] E_PRESS = 5'b00001;
    localparam logic [4:0] E_REL   = 5'b00010;
    localparam logic [4:0] E_LONG  = 5'b00100;
    localparam logic [4:0] E_DBL   = 5'b01000;
    localparam logic [4:0] E_RPT   = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] evt;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic rst_at_edge = 1'b1;
    logic key_smp = 1'b0;

    key_event_if kbus ();

    key_event #(
        .LONG_CYC   (LONG),
        .DBL_CYC    (DBL),
        .REPEAT_CYC (RPT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .kbus (kbus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rstn;
        key_smp     <= kbus.key;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [4:0] e);
        exp_t x;
        x.cyc = c;
        x.evt = e;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: reset cycles must be silent; otherwise every pulse is matched in order.
    always @(negedge clk) begin
        logic [4:0] evt;
        exp_t       x;
        evt = {kbus.rpt, kbus.dbl_click, kbus.long_press, kbus.released, kbus.press};
        if (rst_at_edge) begin
            check_eq("rst_out", {27'd0, evt}, 32'd0);
            check_eq("rst_held", {31'd0, kbus.held}, 32'd0);
        end else begin
            check_eq("held", {31'd0, kbus.held}, {31'd0, key_smp});
            if (evt !== 5'b0) begin
                if (sb.size() == 0) begin
                    check_eq("spurious", {27'd0, evt}, 32'd0);
                end else begin
                    x = sb.pop_front();
                    check_eq("evt", {27'd0, evt}, {27'd0, x.evt});
                    check_eq("evt_edge", cyc, x.cyc);
                end
            end
        end
    end

    // Press, release, second press after "gap" low cycles, release.
    task automatic click_pair(input int gap);
        int t;
        t = cyc;
        kbus.key = 1'b1;
        push(t + 1, E_PRESS);
        wait_cyc(4);
        kbus.key = 1'b0;
        push(t + 5, E_REL);
        wait_cyc(gap);
        kbus.key = 1'b1;
        if (gap <= int'(DBL)) push(t + 5 + gap, E_PRESS | E_DBL);
        else                  push(t + 5 + gap, E_PRESS);
        wait_cyc(2);
        kbus.key = 1'b0;
        push(t + 7 + gap, E_REL);
        wait_cyc(10);
    endtask

    task automatic triple_click();
        int t;
        t = cyc;
        kbus.key = 1'b1; push(t + 1, E_PRESS);
        wait_cyc(2);
        kbus.key = 1'b0; push(t + 3, E_REL);
        wait_cyc(2);
        kbus.key = 1'b1; push(t + 5, E_PRESS | E_DBL);
        wait_cyc(2);
        kbus.key = 1'b0; push(t + 7, E_REL);
        wait_cyc(2);
        kbus.key = 1'b1; push(t + 9, E_PRESS);
        wait_cyc(2);
        kbus.key = 1'b0; push(t + 11, E_REL);
        wait_cyc(10);
    endtask

    // Hold for n cycles (n > LONG), then release and stay low 2 cycles.
    task automatic long_hold(input int n);
        int t;
        t = cyc;
        kbus.key = 1'b1;
        push(t + 1, E_PRESS);
        push(t + 1 + int'(LONG), E_LONG);
`ifdef KEY_REPEAT_EN
        for (int r = t + 1 + int'(LONG) + int'(RPT); r <= t + n; r += int'(RPT)) begin
            push(r, E_RPT);
        end
`endif
        wait_cyc(n);
        kbus.key = 1'b0;
        push(t + n + 1, E_REL);
        wait_cyc(2);
    endtask

    task automatic tap();
        int t;
        t = cyc;
        kbus.key = 1'b1;
        push(t + 1, E_PRESS);
        wait_cyc(2);
        kbus.key = 1'b0;
        push(t + 3, E_REL);
        wait_cyc(10);
    endtask

    task automatic reset_mid_hold();
        int t;
        t = cyc;
        kbus.key = 1'b1;
        push(t + 1, E_PRESS);
        wait_cyc(6);
        rstn = 1'b0;
        wait_cyc(1);
        rstn = 1'b1;
        push(t + 8, E_PRESS);
        push(t + 16, E_LONG);
        wait_cyc(11);
        kbus.key = 1'b0;
        push(t + 19, E_REL);
        wait_cyc(10);
    endtask

    initial begin
        int t;
        rstn = 1'b0;
        kbus.key = 1'b1;
        wait_cyc(3);
        t = cyc;
        rstn = 1'b1;
        push(t + 1, E_PRESS);
        wait_cyc(4);
        kbus.key = 1'b0;
        push(t + 5, E_REL);
        wait_cyc(10);

        click_pair(3);
        click_pair(6);
        click_pair(5);
        click_pair(1);
        triple_click();
        long_hold(12);
        tap();
        long_hold(20);
        tap();
        reset_mid_hold();

        wait_cyc(5);
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Button event decoder that consumes the clean, active-high key level produced by the debounce stage and turns it into single-cycle event pulses: press, release, long press, double click and, optionally, auto-repeat. It sits between the debouncer and the lab's control logic (counters, menu FSMs), so that downstream logic never has to do its own edge detection or timing.

## Interface
- LONG_CYC, 24'd15_000_000, hold cycles from press to long_press (150 ms at 100 MHz)
- DBL_CYC, 24'd10_000_000, max cycles from release to the second press for a double click
- REPEAT_CYC, 24'd5_000_000, auto-repeat period while held past long press (used only with KEY_REPEAT_EN)
- All parameters: range 2 to 24'hffffff, 24-bit counter.
- clk  input  1  system clock
- rstn  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk
- key  input  1  debounced key level, 1 = pressed, synchronous to clk
- press  output  1  one-cycle pulse on each press
- release  output  1  one-cycle pulse on each release
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYC
- dbl_click  output  1  one-cycle pulse, coincident with press, on the second press of a double click
- rpt  output  1  one-cycle auto-repeat pulse; constant 0 without KEY_REPEAT_EN
- held  output  1  registered copy of key (key_q)

## Operation
- key_q <= key on every edge. rise = key & ~key_q; fall = ~key & key_q.
- cnt is 24 bits. It is cleared on every state entry and increments by 1 per cycle in HELD, HELD2, WAIT2 and LONG. It saturates at 24'hffffff and never wraps.
- All outputs are registered. Each pulse is high for exactly one cycle.
- FSM states are IDLE, HELD, WAIT2, HELD2 and LONG.
- IDLE
  - rise -> press, go to HELD.
- HELD
  - fall -> release, go to WAIT2.
  - else cnt==LONG_CYC-1 -> long_press, go to LONG.
- WAIT2
  - rise (checked first) -> press and dbl_click, go to HELD2.
  - else cnt==DBL_CYC-1 -> go to IDLE, no output.
- HELD2
  - fall -> release, go to IDLE.
  - else cnt==LONG_CYC-1 -> long_press, go to LONG.
  - A third press never produces dbl_click.
- LONG
  - fall -> release, go to IDLE. A long press never arms a double click.
  - With KEY_REPEAT_EN: cnt==REPEAT_CYC-1 -> rpt, cnt cleared, stay in LONG.
- Edges only alternate because key is a level, so a rise in HELD, HELD2 or LONG, or a fall in IDLE or WAIT2, is ignored.
- A rise in the same cycle as the WAIT2 timeout counts as a double click (rise wins).
- rstn low at any edge, including mid-hold:
  - State goes to IDLE, cnt to 0 and key_q to 0.
  - All outputs go to 0 at that edge.
  - If key is held through reset, press asserts one cycle after the first edge with rstn high.

## Timing
- Reset values: press, release, long_press, dbl_click, rpt and held are all 0.
- press or release: registered at the edge N where the edge is first sampled; high during cycle N..N+1. Latency is 1 clock.
- long_press: registered at edge N+LONG_CYC, where N is the press edge, if key stays high.
- dbl_click: release registered at edge M, then a rise at edge M+k with 1 ≤ k ≤ DBL_CYC. A rise at M+DBL_CYC+1 or later gives a plain press.
- rpt: registered at edges L+j·REPEAT_CYC (j ≥ 1), where L is the long_press edge.

## Configuration
- KEY_REPEAT_EN
  - Defined: the repeat counter path in LONG is compiled in and rpt pulses as above.
  - Undefined: the repeat logic is absent, rpt is tied to 0, and LONG only waits for fall.

## Structure
- Shared package key_pkg holds:
  - the state typedef (IDLE, HELD, WAIT2, HELD2, LONG);
  - the counter width constant CNT_W = 24;
  - the default cycle constants.
- One sub-module, key_edge, holds the key_q register and produces rise and fall. The FSM and counter stay in key_event.

## Test plan
- LONG_CYC=8, DBL_CYC=5 for all scenarios. With KEY_REPEAT_EN, REPEAT_CYC=3.
- Reset is held low 3 cycles; key is held high 4 cycles, then low 10 cycles -> all outputs 0 during reset; press at edge+1; release at fall edge+1; no long_press, no dbl_click.
- Key high 4, low 3, high 2, low -> press; release; press and dbl_click in the same cycle; release. Repeat with a 6-cycle gap -> no dbl_click. A gap of exactly 5 -> dbl_click.
- Key high 12 cycles -> long_press exactly 8 cycles after press; release on fall; a re-press 2 cycles later -> no dbl_click.
- With KEY_REPEAT_EN, key high 20 cycles -> rpt at 3, 6, 9 cycles after long_press. Without the macro -> rpt stays 0.
- rstn pulled low for 1 cycle at cnt=5 in HELD with key still high -> outputs 0; press reasserts 1 cycle after reset release; long_press 8 cycles after that press.
